// File: rtl/dist_search_if.sv
// dist_search_if: candidate-store read port and distance-unit handshake between the search controller and its peers.
// Ports (master = controller side):
//   cand_rd_en / cand_addr       read strobe and index toward the candidate store
//   dist_ready                   candidate data on the store output is valid for the distance unit
//   dist_finished / dist2        distance-unit result strobe and unsigned score
interface dist_search_if #(
    parameter int IDX_W   = 10,
    parameter int SCORE_W = 39
);
    logic               cand_rd_en;
    logic [IDX_W-1:0]   cand_addr;
    logic               dist_ready;
    logic               dist_finished;
    logic [SCORE_W-1:0] dist2;
    modport master (output cand_rd_en, cand_addr, dist_ready, input dist_finished, dist2);
    modport slave  (input cand_rd_en, cand_addr, dist_ready, output dist_finished, dist2);
endinterface

// File: rtl/dist_search_ctrl.sv
// dist_search_ctrl: sweeps candidate matrices through the distance unit and reports the best-scoring one.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, num_cand, threshold search request; count and early-exit score sampled on start
//   bus (master)               candidate-store read and distance-unit handshake
//   busy, done                 search in progress / one-cycle end-of-search pulse
//   best_idx, best_score       winning candidate, held until next start
//   early_hit, timeout_err     search ended on threshold / aborted by watchdog
module dist_search_ctrl #(
    parameter int IDX_W   = 10,
    parameter int SCORE_W = 39,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [IDX_W:0]     num_cand,
    input  logic [SCORE_W-1:0] threshold,
    dist_search_if.master      bus,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   best_idx,
    output logic [SCORE_W-1:0] best_score,
    output logic               early_hit,
    output logic               timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, CMP, DONE} state_t;
    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, addr_q, addr_d, best_idx_q, best_idx_d;
    logic [IDX_W:0]     num_q, num_d;
    logic [SCORE_W-1:0] thr_q, thr_d, score_q, score_d, best_score_q, best_score_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               early_q, early_d, tmo_q, tmo_d;
    logic               busy_q, busy_d, done_q, done_d, rd_q, rd_d, rdy_q, rdy_d;
    logic               last, upd, hit;
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        num_d        = num_q;
        thr_d        = thr_q;
        wdog_d       = wdog_q;
        score_d      = score_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        early_d      = early_q;
        tmo_d        = tmo_q;
        last         = {1'b0, idx_q} == num_q - 1'b1;
        // first candidate always seeds the best; ties keep the earlier index
        upd          = idx_q == '0 || score_q > best_score_q;
        hit          = thr_q != '0 && score_q >= thr_q;
        case (state_q)
            IDLE: if (start) begin
                num_d        = num_cand;
                thr_d        = threshold;
                best_idx_d   = '0;
                best_score_d = '0;
                early_d      = 1'b0;
                tmo_d        = 1'b0;
                idx_d        = '0;
                state_d      = num_cand == '0 ? DONE : FETCH;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: if (bus.dist_finished) begin
                score_d = bus.dist2;
                state_d = CMP;
            end else begin
                wdog_d = wdog_q + 1'b1;
                if (wdog_d == WD_MAX) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end
            end
            CMP: begin
                if (upd) begin
                    best_idx_d   = idx_q;
                    best_score_d = score_q;
                end
                if (hit) begin
                    early_d = 1'b1;
                    state_d = DONE;
                end else if (last) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // handshake outputs are registered off the next state so they line up with FETCH/LOAD
        rd_d   = state_d == FETCH;
        addr_d = state_d == FETCH ? idx_d : addr_q;
        rdy_d  = state_d == LOAD;
        busy_d = state_d != IDLE;
        done_d = state_q == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            num_q        <= '0;
            thr_q        <= '0;
            wdog_q       <= '0;
            score_q      <= '0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            early_q      <= 1'b0;
            tmo_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            rdy_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            num_q        <= num_d;
            thr_q        <= thr_d;
            wdog_q       <= wdog_d;
            score_q      <= score_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            early_q      <= early_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            rdy_q        <= rdy_d;
        end
    end
    assign bus.cand_rd_en = rd_q;
    assign bus.cand_addr  = addr_q;
    assign bus.dist_ready = rdy_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign best_idx       = best_idx_q;
    assign best_score     = best_score_q;
    assign early_hit      = early_q;
    assign timeout_err    = tmo_q;
endmodule

// File: tb/tb_dist_search_ctrl.sv
// tb_dist_search_ctrl: directed checks of dist_search_ctrl against a latency-L distance-unit model.
module tb_dist_search_ctrl;
    localparam int IW = 10;
    localparam int SW = 39;
    logic clk = 1'b0;
    logic reset, start;
    logic [IW:0] num_cand;
    logic [SW-1:0] threshold;
    logic busy, done, early_hit, timeout_err;
    logic [IW-1:0] best_idx;
    logic [SW-1:0] best_score;
    dist_search_if #(.IDX_W(IW), .SCORE_W(SW)) bus ();
    dist_search_ctrl #(.IDX_W(IW), .SCORE_W(SW), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .start(start), .num_cand(num_cand), .threshold(threshold),
        .bus(bus), .busy(busy), .done(done), .best_idx(best_idx), .best_score(best_score),
        .early_hit(early_hit), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    logic [SW-1:0] scores [16];
    int lat = 3;
    int hold_idx = -1;
    logic spur = 1'b0;
    logic pend = 1'b0;
    int cnt = 0;
    logic [IW-1:0] pidx = '0;
    logic fin_q = 1'b0;
    logic [SW-1:0] d2_q = '0;
    logic spur_now;
    always @(posedge clk) begin
        fin_q <= 1'b0;
        if (reset) pend <= 1'b0;
        else if (bus.dist_ready) begin
            pend <= 1'b1;
            cnt  <= lat - 1;
            pidx <= bus.cand_addr;
        end else if (pend) begin
            if (cnt <= 1) begin
                pend <= 1'b0;
                if (int'(pidx) != hold_idx) begin
                    fin_q <= 1'b1;
                    d2_q  <= scores[pidx[3:0]];
                end
            end else cnt <= cnt - 1;
        end
    end
    assign spur_now = spur && (bus.cand_rd_en || bus.dist_ready);
    assign bus.dist_finished = fin_q || spur_now;
    assign bus.dist2 = spur_now ? '1 : d2_q;
    logic mon_clr = 1'b0;
    int n_rd = 0, n_rdy = 0, n_done = 0, n_busy = 0, max_addr = 0;
    always @(posedge clk) begin
        if (mon_clr) begin
            n_rd = 0; n_rdy = 0; n_done = 0; n_busy = 0; max_addr = 0;
        end else begin
            if (bus.cand_rd_en) begin
                n_rd++;
                if (int'(bus.cand_addr) > max_addr) max_addr = int'(bus.cand_addr);
            end
            if (bus.dist_ready) n_rdy++;
            if (done) n_done++;
            if (busy) n_busy++;
        end
    end
    int n_run = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic clr_mon();
        @(negedge clk) mon_clr = 1'b1;
        @(negedge clk) mon_clr = 1'b0;
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic go(input int n, input logic [SW-1:0] thr, input int xs1, input int xs2, output int cyc);
        int k;
        @(negedge clk);
        num_cand = (IW+1)'(n);
        threshold = thr;
        start = 1'b1;
        k = 0;
        cyc = -1;
        while (k < 500) begin
            @(posedge clk);
            #1;
            k++;
            start = (k == xs1 || k == xs2);
            if (done) begin
                cyc = k;
                break;
            end
        end
        start = 1'b0;
        if (cyc < 0) chk("done_wait", 0, 1);
    endtask
    int cyc;
    initial begin
        reset = 1'b1; start = 1'b0; num_cand = '0; threshold = '0;
        for (int i = 0; i < 16; i++) scores[i] = '0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", bus.cand_rd_en, 0);
        chk("rst_ready", bus.dist_ready, 0);
        chk("rst_best", {best_idx, best_score}, 0);
        chk("rst_flags", {early_hit, timeout_err}, 0);
        @(negedge clk) reset = 1'b0;
        // full sweep, tie on 9 keeps idx 1
        scores[0] = 5; scores[1] = 9; scores[2] = 9; scores[3] = 2;
        clr_mon();
        go(4, 0, -1, -1, cyc);
        chk("t1_cycles", cyc, 26);
        chk("t1_best_idx", best_idx, 1);
        chk("t1_best_score", best_score, 9);
        chk("t1_early", early_hit, 0);
        chk("t1_tmo", timeout_err, 0);
        chk("t1_busy", busy, 0);
        idle(3);
        chk("t1_reads", n_rd, 4);
        chk("t1_readys", n_rdy, 4);
        chk("t1_done_cnt", n_done, 1);
        // early exit at threshold 35
        for (int i = 0; i < 8; i++) scores[i] = SW'(10 * (i + 1));
        clr_mon();
        go(8, 35, -1, -1, cyc);
        chk("t2_cycles", cyc, 26);
        chk("t2_best_idx", best_idx, 3);
        chk("t2_best_score", best_score, 40);
        chk("t2_early", early_hit, 1);
        idle(3);
        chk("t2_reads", n_rd, 4);
        chk("t2_max_addr", max_addr, 3);
        // watchdog on idx 1
        scores[0] = 7; scores[1] = 3; scores[2] = 1;
        hold_idx = 1;
        clr_mon();
        go(3, 0, -1, -1, cyc);
        chk("t3_cycles", cyc, 73);
        chk("t3_tmo", timeout_err, 1);
        chk("t3_early", early_hit, 0);
        chk("t3_best_idx", best_idx, 0);
        chk("t3_best_score", best_score, 7);
        idle(5);
        chk("t3_done_cnt", n_done, 1);
        hold_idx = -1;
        // empty table
        clr_mon();
        go(0, 0, -1, -1, cyc);
        chk("t4_cycles", cyc, 2);
        chk("t4_best", {best_idx, best_score}, 0);
        chk("t4_tmo", timeout_err, 0);
        idle(3);
        chk("t4_busy_cnt", n_busy, 1);
        chk("t4_reads", n_rd, 0);
        chk("t4_readys", n_rdy, 0);
        chk("t4_done_cnt", n_done, 1);
        // reset during WAIT of idx 2
        scores[0] = 5; scores[1] = 9; scores[2] = 9; scores[3] = 2;
        clr_mon();
        @(negedge clk);
        num_cand = 4; threshold = '0; start = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("t5_pre_busy", busy, 1);
        chk("t5_pre_addr", bus.cand_addr, 2);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_addr", bus.cand_addr, 0);
        chk("t5_rst_best", {best_idx, best_score}, 0);
        chk("t5_rst_ready", bus.dist_ready, 0);
        @(negedge clk) reset = 1'b0;
        idle(8);
        chk("t5_no_done", n_done, 0);
        go(4, 0, -1, -1, cyc);
        chk("t5_cycles", cyc, 26);
        chk("t5_best_idx", best_idx, 1);
        chk("t5_best_score", best_score, 9);
        // spurious finished in FETCH/LOAD, extra starts mid-run and in the DONE cycle
        spur = 1'b1;
        clr_mon();
        go(4, 0, 3, 25, cyc);
        chk("t6_cycles", cyc, 26);
        chk("t6_best_idx", best_idx, 1);
        chk("t6_best_score", best_score, 9);
        chk("t6_early", early_hit, 0);
        idle(4);
        chk("t6_busy_after", busy, 0);
        chk("t6_done_cnt", n_done, 1);
        chk("t6_reads", n_rd, 4);
        spur = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
